// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - pipelined radix-2 DIT complex butterfly with handshake, scaling and saturation
module butterfly_pipe #(
  parameter int DW = 12,
  parameter int TW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        x_re,
  output logic [DW-1:0]        x_im,
  output logic [DW-1:0]        y_re,
  output logic [DW-1:0]        y_im,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  localparam int PW = DW + TW;   // raw product width
  localparam int SW = DW + 2;    // rounded product / sum width

  localparam logic [PW:0]   RND     = {{(PW-TW+3){1'b0}}, 1'b1, {(TW-3){1'b0}}};
  localparam logic [SW:0]   ONE     = {{SW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // One global advance: every stage moves unless a valid output is being held.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1 registers
  logic                 s1_valid, s1_scale;
  logic signed [DW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic signed [TW-1:0] s1_tw_re, s1_tw_im;

  // Stage 2 registers
  logic                 s2_valid, s2_scale;
  logic [DW-1:0]        s2_a_re, s2_a_im;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

  // Stage 3 combinational datapath
  logic [PW:0]          p_re, p_im, r_re, r_im;
  logic [SW-1:0]        pp_re, pp_im, a_re_x, a_im_x;
  logic [3:0][SW-1:0]   sum;
  logic [3:0][SW:0]     scl_t;
  logic [3:0][SW-1:0]   scaled;
  logic [3:0][DW-1:0]   res;
  logic [3:0]           of;
  logic                 unused_bits;

  // Stage 1: capture the operands and the scale flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_tw_re <= '0;
      s1_tw_im <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_scale <= scale;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_b_re  <= b_re;
      s1_b_im  <= b_im;
      s1_tw_re <= tw_re;
      s1_tw_im <= tw_im;
    end
  end

  // Stage 2: the four partial products of B*W, carrying A alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      m_rr     <= '0;
      m_ii     <= '0;
      m_ri     <= '0;
      m_ir     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      m_rr     <= s1_b_re * s1_tw_re;
      m_ii     <= s1_b_im * s1_tw_im;
      m_ri     <= s1_b_re * s1_tw_im;
      m_ir     <= s1_b_im * s1_tw_re;
    end
  end

  // Stage 3 combine: complex product, round, add/sub, optional halving, saturate
  always_comb begin
    p_re   = {m_rr[PW-1], m_rr} - {m_ii[PW-1], m_ii};
    p_im   = {m_ri[PW-1], m_ri} + {m_ir[PW-1], m_ir};
    r_re   = p_re + RND;
    r_im   = p_im + RND;
    // Taking bits from TW-2 upward is the arithmetic shift, kept at SW bits.
    pp_re  = r_re[TW-2 +: SW];
    pp_im  = r_im[TW-2 +: SW];
    a_re_x = {{2{s2_a_re[DW-1]}}, s2_a_re};
    a_im_x = {{2{s2_a_im[DW-1]}}, s2_a_im};
    sum[0] = a_re_x + pp_re;
    sum[1] = a_im_x + pp_im;
    sum[2] = a_re_x - pp_re;
    sum[3] = a_im_x - pp_im;
    for (int i = 0; i < 4; i++) begin
      // One extra bit so the +1 of round-half-up cannot wrap before the shift.
      scl_t[i]  = {sum[i][SW-1], sum[i]} + ONE;
      scaled[i] = s2_scale ? scl_t[i][SW:1] : sum[i];
      of[i]     = !((&scaled[i][SW-1:DW-1]) || !(|scaled[i][SW-1:DW-1]));
      if (!of[i]) begin
        res[i] = scaled[i][DW-1:0];
      end else if (scaled[i][SW-1]) begin
        res[i] = SAT_MIN;
      end else begin
        res[i] = SAT_MAX;
      end
    end
  end

  assign unused_bits = ^{r_re[TW-3:0], r_re[PW], r_im[TW-3:0], r_im[PW],
                         scl_t[0][0], scl_t[1][0], scl_t[2][0], scl_t[3][0]};

  // Stage 3 registers: the visible outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      x_re      <= res[0];
      x_im      <= res[1];
      y_re      <= res[2];
      y_im      <= res[3];
      ovf       <= s2_valid && (|of);
    end
  end

  // Sticky overflow: records saturation on delivered outputs; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && ovf) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - scoreboard bench for butterfly_pipe
module tb_butterfly_pipe;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [11:0] tw_re = '0, tw_im = '0;
  logic              scale = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [11:0]       x_re, x_im, y_re, y_im;
  logic              ovf;
  logic              ovf_clr = 1'b0;
  logic              ovf_sticky;

  typedef struct {
    int xr; int xi; int yr; int yi; int ov;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  butterfly_pipe #(.DW(12), .TW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_re(tw_re), .tw_im(tw_im), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  // Monitor: pop and compare on every handshake; verify stall holds outputs
  int   held = 0;
  exp_t hv;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (out_valid && held != 0) begin
          chk("hold_x_re", sx(x_re), hv.xr);
          chk("hold_y_im", sx(y_im), hv.yi);
        end
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", int'(in_ready), 0);
          held = 1;
          hv.xr = sx(x_re); hv.xi = sx(x_im); hv.yr = sx(y_re); hv.yi = sx(y_im); hv.ov = int'(ovf);
        end else begin
          held = 0;
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              chk("unexpected_output", 1, 0);
            end else begin
              exp_t e;
              e = q.pop_front();
              chk("x_re", sx(x_re), e.xr);
              chk("x_im", sx(x_im), e.xi);
              chk("y_re", sx(y_re), e.yr);
              chk("y_im", sx(y_im), e.yi);
              chk("ovf",  int'(ovf), e.ov);
            end
          end
        end
      end
    end
  end

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input int sc,
                      input int xr, input int xi, input int yr, input int yi, input int ov);
    int guard;
    exp_t e;
    @(negedge clk);
    a_re = 12'(ar); a_im = 12'(ai); b_re = 12'(br); b_im = 12'(bi);
    tw_re = 12'(wr); tw_im = 12'(wi); scale = sc[0]; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", guard, 0);
    @(posedge clk);
    e.xr = xr; e.xi = xi; e.yr = yr; e.yi = yi; e.ov = ov;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", q.size(), 0);
  endtask

  // Called right after an accepting edge; counts edges until out_valid
  task automatic check_latency(input string name);
    int lat;
    lat = 1;
    fork
      idle();
      begin
        while (lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
          if (out_valid) break;
        end
      end
    join
    chk(name, lat, 3);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_ovf_sticky", int'(ovf_sticky), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_x_re", sx(x_re), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity twiddle with latency measurement
    send(100, -50, 20, 30, 1024, 0, 0, 120, -20, 80, -80, 0);
    check_latency("latency_identity");
    drain();

    // Saturation, then sticky set and clear
    send(2000, 0, 100, 0, 1024, 0, 0, 2047, 0, 1900, 0, 1);
    idle();
    drain();
    @(posedge clk); #1;
    chk("sticky_set", int'(ovf_sticky), 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("sticky_clr", int'(ovf_sticky), 0);
    @(negedge clk); ovf_clr = 1'b0;

    // Back-to-back directed vectors
    send(100, -50, 20, 30, 0, -1024, 0, 130, -70, 70, -30, 0);
    send(2000, 0, 100, 0, 1024, 0, 1, 1050, 0, 950, 0, 0);
    send(3, -3, 0, 0, 1024, 0, 1, 2, -1, 2, -1, 0);
    send(0, 0, 1, 0, 512, 0, 0, 1, 0, -1, 0, 0);
    send(-2048, -2048, 0, 0, 1024, 0, 0, -2048, -2048, -2048, -2048, 0);
    send(0, 0, -2048, 0, -1024, 0, 0, 2047, 0, -2048, 0, 1);
    idle();
    drain();

    // Ten-sample stream with backpressure in cycles 4..8
    fork
      begin
        for (int i = 1; i <= 10; i++)
          send(10*i, -i, i, 2*i, 1024, 0, 0, 11*i, i, 9*i, -3*i, 0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_queue_empty", q.size(), 0);
    chk("sticky_before_rst", int'(ovf_sticky), 1);

    // Reset with three samples in flight
    send(100, -50, 20, 30, 1024, 0, 0, 120, -20, 80, -80, 0);
    send(100, -50, 20, 30, 1024, 0, 0, 120, -20, 80, -80, 0);
    send(100, -50, 20, 30, 1024, 0, 0, 120, -20, 80, -80, 0);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sticky", int'(ovf_sticky), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    send(100, -50, 20, 30, 0, -1024, 0, 130, -70, 70, -30, 0);
    check_latency("latency_after_reset");
    drain();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath in the audio-processing chain.
- Computes X = A + B·W and Y = A − B·W on signed complex samples, with the twiddle W supplied per transaction.
- Adds a valid/ready handshake with backpressure, optional per-sample divide-by-2 scaling, convergent-free round-half-up, saturation, and overflow flags.
- Drop-in for any FFT stage; the caller's twiddle table drives tw_re/tw_im.

Parameters:
- DW, 12, sample width, signed two's complement, per real/imag component.
- TW, 12, twiddle width, signed Q2.(TW-2); +1.0 = 2^(TW-2) = 1024 at default.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block can accept input this cycle.
- a_re, a_im  in  DW each  upper input A.
- b_re, b_im  in  DW each  lower input B.
- tw_re, tw_im  in  TW each  twiddle W.
- scale  in  1  1 = halve both outputs; travels with the sample.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts output.
- x_re, x_im  out  DW each  X = A + B·W.
- y_re, y_im  out  DW each  Y = A − B·W.
- ovf  out  1  a component of this output saturated; qualified by out_valid.
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- ovf_sticky  out  1  set on any saturation since reset or clear.

Behaviour:
- Reset: all valid bits, data registers, ovf and ovf_sticky are 0; in_ready is 1 after reset.
- Pipeline: 3 register stages with a single global advance en = !out_valid || out_ready; in_ready = en.
  - Latency is 3 cycles from an accepted input (in_valid && in_ready) to out_valid when there is no stall.
  - Throughput is 1 sample per cycle.
- S1: register A, B, W and scale with a valid bit.
- S2: four signed products br·wr, bi·wi, br·wi, bi·wr, each DW+TW bits, registered with A, scale and valid.
- S3 combine:
  - Pr = br·wr − bi·wi and Pi = br·wi + bi·wr, each DW+TW+1 bits.
  - Round: P' = (P + 2^(TW-3)) >>> (TW-2), kept at DW+2 bits.
  - Sums: X = A + P' and Y = A − P', at DW+2 bits.
  - If scale: v = (v + 1) >>> 1, round half up, applied per component.
  - Saturate each component to [−2^(DW-1), 2^(DW-1)−1]; ovf = OR of the four saturations.
  - Register all results with valid.
- Stall: when out_ready = 0 and out_valid = 1, every stage holds, outputs stay stable, and in_ready = 0.
  - No data is lost or duplicated; order is preserved.
  - Bubbles (valid = 0) advance normally, so an empty stage does not block.
- ovf_sticky: set in any cycle where out_valid && out_ready && ovf.
  - ovf_clr has priority in the same cycle: the sticky bit is cleared and that cycle's event is not captured.
- in_valid with in_ready = 0: the input is ignored and the source must hold it.
- Reset asserted mid-stream: in-flight samples are discarded immediately and asynchronously; out_valid drops to 0.
- Twiddle −1.0 (−2^(TW-2)) is legal. Inputs of −2^(DW-1) are legal and overflow only through the saturate path.

Test Plan:
- Identity twiddle (1024, 0), A=(100,−50), B=(20,30), scale=0, out_ready=1 → 3 cycles later out_valid=1, X=(120,−20), Y=(80,−80), ovf=0.
- Twiddle −j (0,−1024), same A and B → B·W=(30,−20), X=(130,−70), Y=(70,−30).
- Saturation: A=(2000,0), B=(100,0), W=(1024,0), scale=0 → X=(2047,0), Y=(1900,0), ovf=1, ovf_sticky=1. Pulsing ovf_clr → ovf_sticky=0 the next cycle. Same input with scale=1 → X=(1050,0), Y=(950,0), ovf=0.
- Rounding: scale=1, B=0, W=(1024,0), A=(3,−3) → X=(2,−1), Y=(2,−1). B=(1,0), W=(512,0) (0.5·1 rounds up) → P'=1.
- Backpressure: stream 10 consecutive samples while out_ready is held low for cycles 4–8 → in_ready=0 while the pipe is full, outputs hold stable, all 10 results emerge in order with none dropped.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight → out_valid=0 and ovf_sticky=0 immediately. After release, a new sample appears exactly 3 cycles after acceptance.
